// File: rtl/fpga_shift_unit_if.sv
// Request and result channels of the shift unit. The master side drives
// requests and consumes results; the slave side is the shift unit itself.
interface fpga_shift_unit_if #(
  parameter int W = 12
);
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   in_op;
  logic [W-1:0] in_data;
  logic [W-1:0] in_amount;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_err;

  modport master (
    output in_valid, in_op, in_data, in_amount, out_ready,
    input  in_ready, out_valid, out_data, out_err
  );

  modport slave (
    input  in_valid, in_op, in_data, in_amount, out_ready,
    output in_ready, out_valid, out_data, out_err
  );
endinterface

// File: rtl/fpga_shift_unit.sv
// Iterative multi-mode shifter (SHL/SHR/SAR/ROL/ROR) moving up to StepBits
// bits per cycle, with results queued in a circular output channel.
module fpga_shift_unit #(
  parameter int MemoryElementWidth = 12,
  parameter int StepBits           = 1,
  parameter int NOut               = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  fpga_shift_unit_if.slave          bus,
  output logic [$clog2(NOut+1)-1:0] out_count,
  output logic                      busy,
  output logic [31:0]               ops_done
);
  localparam int W  = MemoryElementWidth;
  localparam int AW = $clog2(W + 1);
  localparam int PW = (NOut > 1) ? $clog2(NOut) : 1;
  localparam int CW = $clog2(NOut + 1);

  localparam logic [AW-1:0] W_AMT    = AW'(W);
  localparam logic [W-1:0]  W_DATA   = W'(W);
  localparam logic [AW-1:0] STEP     = AW'(StepBits);
  localparam logic [CW-1:0] DEPTH    = CW'(NOut);
  localparam logic [PW-1:0] LAST_PTR = PW'(NOut - 1);

  typedef enum logic [2:0] {
    OP_SHL = 3'd0,
    OP_SHR = 3'd1,
    OP_SAR = 3'd2,
    OP_ROL = 3'd3,
    OP_ROR = 3'd4
  } op_e;

  typedef enum logic [1:0] {IDLE, SHIFT, PUSH} state_e;

  state_e        state;
  logic [2:0]    op_q;
  logic          err_q;
  logic          sign_q;
  logic [W-1:0]  work_q;
  logic [AW-1:0] rem_q;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [W-1:0]  rd_data_q;
  logic          rd_err_q;

  logic [W-1:0]  mem_data [NOut];
  logic          mem_err  [NOut];

  logic          accept;
  logic [AW-1:0] eff;
  logic          eff_err;
  logic [AW-1:0] step_amt;
  logic [AW-1:0] rem_nx;
  logic [W-1:0]  work_nx;
  logic          push;
  logic          pop;
  logic [PW-1:0] head_nx;
  logic [CW-1:0] count_nx;
  logic [W-1:0]  rd_data_nx;
  logic          rd_err_nx;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // One partial shift of s bits; the SAR fill uses the sign latched at accept.
  function automatic logic [W-1:0] step_shift(input logic [2:0]    op,
                                              input logic [W-1:0]  v,
                                              input logic [AW-1:0] s,
                                              input logic          sign);
    logic [W-1:0] r;
    r = v;
    case (op)
      OP_SHL:  r = v << s;
      OP_SHR:  r = v >> s;
      OP_SAR:  r = (v >> s) | (sign ? ~({W{1'b1}} >> s) : '0);
      OP_ROL:  r = (v << s) | (v >> (W_AMT - s));
      OP_ROR:  r = (v >> s) | (v << (W_AMT - s));
      default: r = v;
    endcase
    return r;
  endfunction

  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.in_ready  = reset && (state == IDLE) && (count < DEPTH);
  assign bus.out_valid = (count != '0);
  assign bus.out_data  = rd_data_q;
  assign bus.out_err   = rd_err_q;
  assign out_count     = count;
  assign busy          = (state != IDLE);

  // Effective amount: linear shifts saturate at W, rotates wrap modulo W.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    eff     = '0;
    eff_err = 1'b0;
    case (bus.in_op)
      OP_SHL, OP_SHR, OP_SAR: eff = (bus.in_amount >= W_DATA) ? W_AMT : AW'(bus.in_amount);
      OP_ROL, OP_ROR:         eff = AW'(bus.in_amount % W_DATA);
      default:                eff_err = 1'b1;
    endcase
  end

  // Datapath for one SHIFT cycle.
  always_comb begin
    step_amt = (rem_q > STEP) ? STEP : rem_q;
    rem_nx   = rem_q - step_amt;
    work_nx  = step_shift(op_q, work_q, step_amt, sign_q);
  end

  // Channel bookkeeping and the next registered head read (bypass when the
  // slot being written this edge becomes the head).
  always_comb begin
    push     = (state == PUSH);
    pop      = (count != '0) && bus.out_ready;
    head_nx  = pop ? ptr_inc(head) : head;
    count_nx = count + CW'(push) - CW'(pop);
    if (count_nx == '0) begin
      rd_data_nx = '0;
      rd_err_nx  = 1'b0;
    end else if (push && (head_nx == tail)) begin
      rd_data_nx = work_q;
      rd_err_nx  = err_q;
    end else begin
      rd_data_nx = mem_data[head_nx];
      rd_err_nx  = mem_err[head_nx];
    end
  end

  // Control FSM, operand registers, channel pointers and counters.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      op_q      <= '0;
      err_q     <= 1'b0;
      sign_q    <= 1'b0;
      work_q    <= '0;
      rem_q     <= '0;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      rd_data_q <= '0;
      rd_err_q  <= 1'b0;
      ops_done  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      head      <= head_nx;
      count     <= count_nx;
      rd_data_q <= rd_data_nx;
      rd_err_q  <= rd_err_nx;
      case (state)
        IDLE: begin
          if (accept) begin
            op_q   <= bus.in_op;
            err_q  <= eff_err;
            sign_q <= bus.in_data[W-1];
            work_q <= bus.in_data;
            rem_q  <= eff;
            state  <= (eff != '0) ? SHIFT : PUSH;
          end
        end
        SHIFT: begin
          work_q <= work_nx;
          rem_q  <= rem_nx;
          if (rem_nx == '0) state <= PUSH;
        end
        PUSH: begin
          tail     <= ptr_inc(tail);
          ops_done <= ops_done + 32'd1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Channel storage write.
  // NOTE: the storage array has no reset; a slot is only read after the count shows it was written.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_data[tail] <= work_q;
      mem_err[tail]  <= err_q;
    end
  end
endmodule

// File: tb/tb_fpga_shift_unit.sv
// Directed bench for fpga_shift_unit: one StepBits=1 instance for most
// scenarios and one StepBits=4 instance for the multi-bit step timing.
module tb_fpga_shift_unit;
  localparam int W = 12;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  int          total = 0;
  int          bad   = 0;

  logic [2:0]  cnt1, cnt4;
  logic        busy1, busy4;
  logic [31:0] done1, done4;

  fpga_shift_unit_if #(.W(W)) bus  ();
  fpga_shift_unit_if #(.W(W)) bus4 ();

  fpga_shift_unit #(.MemoryElementWidth(W), .StepBits(1), .NOut(4)) dut (
    .clock(clock), .reset(reset), .bus(bus),
    .out_count(cnt1), .busy(busy1), .ops_done(done1)
  );

  fpga_shift_unit #(.MemoryElementWidth(W), .StepBits(4), .NOut(4)) dut4 (
    .clock(clock), .reset(reset), .bus(bus4),
    .out_count(cnt4), .busy(busy4), .ops_done(done4)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present a request on the StepBits=1 unit and hold it until accepted.
  task automatic send(input logic [2:0] op, input logic [W-1:0] d, input logic [W-1:0] a);
    int n;
    n = 0;
    bus.in_valid  = 1'b1;
    bus.in_op     = op;
    bus.in_data   = d;
    bus.in_amount = a;
    while (bus.in_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL send_timeout in_ready=%b want=1", bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Wait for a head entry, capture it, and pop it.
  task automatic pop(output logic [W-1:0] d, output logic e);
    int n;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    total++;
    if (bus.out_valid !== 1'b1) begin
      bad++;
      $display("FAIL pop_timeout out_valid=%b want=1", bus.out_valid);
    end
    d = bus.out_data;
    e = bus.out_err;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    #1;
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b want=0", bus.in_ready); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.out_data !== 12'h000) begin bad++; $display("FAIL rst_out_data got=%h want=000", bus.out_data); end
    total++; if (bus.out_err !== 1'b0) begin bad++; $display("FAIL rst_out_err got=%b want=0", bus.out_err); end
    total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy1); end
    total++; if (done1 !== 32'd0) begin bad++; $display("FAIL rst_ops_done got=%0d want=0", done1); end
    total++; if (cnt1 !== 3'd0) begin bad++; $display("FAIL rst_out_count got=%0d want=0", cnt1); end
    tick();
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL rst_held_in_ready got=%b want=0", bus.in_ready); end
    reset = 1'b1;
    tick();
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL post_rst_in_ready got=%b want=1", bus.in_ready); end
  endtask

  task automatic test_shl_basic();
    logic [W-1:0] d;
    logic         e;
    send(3'd0, 12'h001, 12'd1);
    total++; if (busy1 !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b want=1", busy1); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL basic_valid_e0 got=%b want=0", bus.out_valid); end
    tick();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL basic_valid_e1 got=%b want=0", bus.out_valid); end
    tick();
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid_e2 got=%b want=1", bus.out_valid); end
    total++; if (bus.out_data !== 12'h002) begin bad++; $display("FAIL basic_data got=%h want=002", bus.out_data); end
    total++; if (bus.out_err !== 1'b0) begin bad++; $display("FAIL basic_err got=%b want=0", bus.out_err); end
    total++; if (done1 !== 32'd1) begin bad++; $display("FAIL basic_ops_done got=%0d want=1", done1); end
    total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL basic_idle got=%b want=0", busy1); end
    pop(d, e);
    total++; if (cnt1 !== 3'd0) begin bad++; $display("FAIL basic_count_after_pop got=%0d want=0", cnt1); end
    total++; if (bus.out_data !== 12'h000) begin bad++; $display("FAIL basic_empty_data got=%h want=000", bus.out_data); end
  endtask

  task automatic test_linear_shifts();
    logic [W-1:0] d;
    logic         e;
    logic [W-1:0] exp_d [4];
    int           n;
    exp_d = '{12'h000, 12'hF00, 12'hFFF, 12'h001};
    send(3'd0, 12'h801, 12'd12);
    send(3'd2, 12'h800, 12'd3);
    send(3'd2, 12'h800, 12'd40);
    send(3'd1, 12'h800, 12'd11);
    n = 0;
    while (cnt1 !== 3'd4 && n < 100) begin tick(); n++; end
    total++; if (cnt1 !== 3'd4) begin bad++; $display("FAIL lin_count got=%0d want=4", cnt1); end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL lin_full_ready got=%b want=0", bus.in_ready); end
    for (int i = 0; i < 4; i++) begin
      pop(d, e);
      total++; if (d !== exp_d[i] || e !== 1'b0) begin bad++; $display("FAIL lin_result_%0d got=%h/%b want=%h/0", i, d, e, exp_d[i]); end
    end
    total++; if (done1 !== 32'd5) begin bad++; $display("FAIL lin_ops_done got=%0d want=5", done1); end
  endtask

  task automatic test_rotate();
    logic [W-1:0] d;
    logic         e;
    send(3'd3, 12'h801, 12'd13);
    pop(d, e);
    total++; if (d !== 12'h003) begin bad++; $display("FAIL rol_13 got=%h want=003", d); end
    send(3'd4, 12'h003, 12'd1);
    pop(d, e);
    total++; if (d !== 12'h801) begin bad++; $display("FAIL ror_1 got=%h want=801", d); end
    send(3'd3, 12'hABC, 12'd12);
    total++; if (busy1 !== 1'b1 || bus.out_valid !== 1'b0) begin bad++; $display("FAIL rol_w_e0 busy/valid got=%b/%b want=1/0", busy1, bus.out_valid); end
    tick();
    total++; if (bus.out_valid !== 1'b1 || busy1 !== 1'b0) begin bad++; $display("FAIL rol_w_e1 valid/busy got=%b/%b want=1/0", bus.out_valid, busy1); end
    total++; if (bus.out_data !== 12'hABC) begin bad++; $display("FAIL rol_w_data got=%h want=abc", bus.out_data); end
    pop(d, e);
  endtask

  task automatic test_full_wrap();
    logic [W-1:0] d;
    logic         e;
    logic [W-1:0] exp_d [3];
    int           n;
    exp_d = '{12'h100, 12'h07F, 12'h03C};
    send(3'd0, 12'h003, 12'd1);
    send(3'd1, 12'h100, 12'd4);
    send(3'd4, 12'h001, 12'd4);
    send(3'd2, 12'h7F0, 12'd4);
    n = 0;
    while (cnt1 !== 3'd4 && n < 100) begin tick(); n++; end
    total++; if (cnt1 !== 3'd4 || bus.in_ready !== 1'b0) begin bad++; $display("FAIL full_state count/ready got=%0d/%b want=4/0", cnt1, bus.in_ready); end
    bus.in_valid  = 1'b1;
    bus.in_op     = 3'd0;
    bus.in_data   = 12'h00F;
    bus.in_amount = 12'd2;
    tick(); tick(); tick();
    total++; if (busy1 !== 1'b0 || cnt1 !== 3'd4) begin bad++; $display("FAIL full_blocked busy/count got=%b/%0d want=0/4", busy1, cnt1); end
    total++; if (bus.out_data !== 12'h006) begin bad++; $display("FAIL full_head got=%h want=006", bus.out_data); end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    total++; if (cnt1 !== 3'd3 || bus.in_ready !== 1'b1) begin bad++; $display("FAIL full_after_pop count/ready got=%0d/%b want=3/1", cnt1, bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    total++; if (busy1 !== 1'b1 || bus.out_data !== 12'h010) begin bad++; $display("FAIL fifth_accept busy/head got=%b/%h want=1/010", busy1, bus.out_data); end
    tick(); tick();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    total++; if (cnt1 !== 3'd3 || bus.out_data !== 12'h100) begin bad++; $display("FAIL push_pop count/head got=%0d/%h want=3/100", cnt1, bus.out_data); end
    total++; if (done1 !== 32'd13) begin bad++; $display("FAIL wrap_ops_done got=%0d want=13", done1); end
    for (int i = 0; i < 3; i++) begin
      pop(d, e);
      total++; if (d !== exp_d[i]) begin bad++; $display("FAIL wrap_order_%0d got=%h want=%h", i, d, exp_d[i]); end
    end
  endtask

  task automatic test_illegal_and_hold();
    logic [W-1:0] d;
    logic         e;
    send(3'd6, 12'h5A5, 12'd3);
    pop(d, e);
    total++; if (d !== 12'h5A5 || e !== 1'b1) begin bad++; $display("FAIL illegal got=%h/%b want=5a5/1", d, e); end
    send(3'd0, 12'h001, 12'd3);
    bus.in_op     = 3'd4;
    bus.in_data   = 12'hFFF;
    bus.in_amount = 12'd7;
    pop(d, e);
    total++; if (d !== 12'h008 || e !== 1'b0) begin bad++; $display("FAIL input_hold got=%h/%b want=008/0", d, e); end
    bus.in_op     = 3'd0;
    bus.in_data   = '0;
    bus.in_amount = '0;
  endtask

  task automatic test_step4();
    int n;
    n = 0;
    bus4.in_valid  = 1'b1;
    bus4.in_op     = 3'd0;
    bus4.in_data   = 12'h001;
    bus4.in_amount = 12'd9;
    while (bus4.in_ready !== 1'b1 && n < 100) begin tick(); n++; end
    total++; if (bus4.in_ready !== 1'b1) begin bad++; $display("FAIL step4_ready got=%b want=1", bus4.in_ready); end
    tick();
    bus4.in_valid = 1'b0;
    n = 0;
    while (busy4 === 1'b1 && n < 50) begin n++; tick(); end
    total++; if (n != 4) begin bad++; $display("FAIL step4_busy_cycles got=%0d want=4", n); end
    total++; if (bus4.out_valid !== 1'b1 || bus4.out_data !== 12'h200) begin bad++; $display("FAIL step4_result valid/data got=%b/%h want=1/200", bus4.out_valid, bus4.out_data); end
    total++; if (cnt4 !== 3'd1 || done4 !== 32'd1) begin bad++; $display("FAIL step4_counts count/done got=%0d/%0d want=1/1", cnt4, done4); end
  endtask

  task automatic test_reset_mid_shift();
    send(3'd0, 12'h001, 12'd10);
    tick(); tick();
    total++; if (busy1 !== 1'b1) begin bad++; $display("FAIL mid_pre_busy got=%b want=1", busy1); end
    #2 reset = 1'b0;
    #1;
    total++; if (busy1 !== 1'b0 || bus.out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst busy/valid got=%b/%b want=0/0", busy1, bus.out_valid); end
    total++; if (done1 !== 32'd0 || cnt1 !== 3'd0) begin bad++; $display("FAIL mid_rst done/count got=%0d/%0d want=0/0", done1, cnt1); end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_ready got=%b want=0", bus.in_ready); end
    tick(); tick();
    reset = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    total++; if (bus.out_valid !== 1'b0 || done1 !== 32'd0 || busy1 !== 1'b0) begin bad++; $display("FAIL mid_after valid/done/busy got=%b/%0d/%b want=0/0/0", bus.out_valid, done1, busy1); end
  endtask

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_op      = '0;
    bus.in_data    = '0;
    bus.in_amount  = '0;
    bus.out_ready  = 1'b0;
    bus4.in_valid  = 1'b0;
    bus4.in_op     = '0;
    bus4.in_data   = '0;
    bus4.in_amount = '0;
    bus4.out_ready = 1'b0;
    test_reset();
    test_shl_basic();
    test_linear_shifts();
    test_rotate();
    test_full_wrap();
    test_illegal_and_hold();
    test_step4();
    test_reset_mid_shift();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
